// File: rtl/cfa_scan_ctrl.sv
// cfa_scan_ctrl: raster-scan (row, col) sequencer with Bayer phase and frame-position flags.
//   Inputs : clk, rst (sync, active-high), start, col_max, row_max, out_ready.
//   Outputs: out_valid, row, col, bayer_phase, first_pix, last_pix, border, busy, done.
//   Optional: define CFA_SCAN_BORDER_EN to build the outer-ring border flag (else tied 0).
module cfa_scan_ctrl #(
  parameter int rowBitWidth = 11,
  parameter int colBitWidth = 11,
  parameter logic [1:0] CFA_PATTERN = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [colBitWidth-1:0] col_max,
  input  logic [rowBitWidth-1:0] row_max,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [rowBitWidth-1:0] row,
  output logic [colBitWidth-1:0] col,
  output logic [1:0]             bayer_phase,
  output logic                   first_pix,
  output logic                   last_pix,
  output logic                   border,
  output logic                   busy,
  output logic                   done
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [rowBitWidth-1:0] R1 = 1;
  localparam logic [colBitWidth-1:0] C1 = 1;
  logic [1:0] state;
  logic [colBitWidth-1:0] cm, dc, nc;
  logic [rowBitWidth-1:0] rm, dr, nr;
  logic load, adv, fin, empty;
  // The next beat's coordinates and the dimensions it is judged against; in IDLE
  // that is the (0,0) beat of the frame about to be captured from the inputs.
  always_comb begin
    dc = state == IDLE ? col_max : cm;
    dr = state == IDLE ? row_max : rm;
    nc = (state == IDLE || col == cm - C1) ? '0 : col + C1;
    nr = state == IDLE ? '0 : (col == cm - C1 ? row + R1 : row);
  end
  assign load  = state == IDLE && start && col_max != '0 && row_max != '0;
  assign empty = state == IDLE && start && !load;
  assign adv   = state == RUN && out_valid && out_ready;
  assign fin   = adv && last_pix;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cm          <= '0;
      rm          <= '0;
      out_valid   <= 1'b0;
      row         <= '0;
      col         <= '0;
      bayer_phase <= 2'b00;
      first_pix   <= 1'b0;
      last_pix    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state == IDLE ? (load ? RUN : empty ? DONE : IDLE) : state == RUN ? (fin ? DONE : RUN) : IDLE;
      done  <= empty || fin;
      busy  <= state == IDLE ? start : state == RUN;
      if (load) begin
        cm <= col_max;
        rm <= row_max;
      end
      if (load || adv) begin
        out_valid   <= !fin;
        row         <= fin ? '0 : nr;
        col         <= fin ? '0 : nc;
        bayer_phase <= fin ? 2'b00 : {nr[0] ^ CFA_PATTERN[1], nc[0] ^ CFA_PATTERN[0]};
        first_pix   <= !fin && nr == '0 && nc == '0;
        last_pix    <= !fin && nr == dr - R1 && nc == dc - C1;
      end
    end
  end
`ifdef CFA_SCAN_BORDER_EN
  always_ff @(posedge clk) begin
    if (rst) border <= 1'b0;
    else if (load || adv) border <= !fin && (nr == '0 || nr == dr - R1 || nc == '0 || nc == dc - C1);
  end
`else
  assign border = 1'b0;
`endif
endmodule

// File: tb/tb_cfa_scan_ctrl.sv
// tb_cfa_scan_ctrl: randomized and directed bench for cfa_scan_ctrl against a queue-based frame model.
module tb_cfa_scan_ctrl;
  localparam logic [1:0] P = 2'b00;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [10:0] col_max = '0, row_max = '0, row, col;
  logic out_valid, first_pix, last_pix, border, busy, done;
  logic [1:0] bayer_phase;
  int checks = 0, fails = 0;
  bit arm = 0;
  int q[$];
  int mw = 0, mh = 0;
  bit dn = 0;
  always #5 clk = ~clk;
  cfa_scan_ctrl #(.rowBitWidth(11), .colBitWidth(11), .CFA_PATTERN(P)) dut (
    .clk(clk), .rst(rst), .start(start), .col_max(col_max), .row_max(row_max),
    .out_ready(out_ready), .out_valid(out_valid), .row(row), .col(col),
    .bayer_phase(bayer_phase), .first_pix(first_pix), .last_pix(last_pix),
    .border(border), .busy(busy), .done(done)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask
  // Model: the frame is a queue of pending (row, col) beats; head is what must be on the outputs.
  always @(negedge clk) if (arm) begin
    int er, ec, eb;
    bit ev;
    ev = q.size() != 0;
    er = ev ? q[0] / 4096 : 0;
    ec = ev ? q[0] % 4096 : 0;
`ifdef CFA_SCAN_BORDER_EN
    eb = int'(ev && (er == 0 || er == mh - 1 || ec == 0 || ec == mw - 1));
`else
    eb = 0;
`endif
    chk("valid", int'(out_valid), int'(ev));
    chk("row", int'(row), er);
    chk("col", int'(col), ec);
    chk("phase", int'(bayer_phase), (((er & 1) << 1) | (ec & 1)) ^ int'(P));
    chk("first", int'(first_pix), int'(ev && er == 0 && ec == 0));
    chk("last", int'(last_pix), int'(ev && er == mh - 1 && ec == mw - 1));
    chk("border", int'(border), eb);
    chk("done", int'(done), int'(dn));
    chk("busy", int'(busy), int'(ev || dn));
    if (rst) begin
      q.delete();
      dn = 0;
    end else if (dn) dn = 0;
    else if (ev) begin
      if (out_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) dn = 1;
      end
    end else if (start) begin
      if (col_max != 0 && row_max != 0) begin
        mw = int'(col_max);
        mh = int'(row_max);
        for (int r = 0; r < mh; r++) for (int c = 0; c < mw; c++) q.push_back(r * 4096 + c);
      end else dn = 1;
    end
  end
  // md: 0 ready=1, 1 random ready, 2 stall beats 2 and 7 for two cycles, 3 ready=1 with start/dims noise.
  task automatic frame(input int w, input int h, input int md, output int cyc, output int nb, output int nbz);
    int held = 0, lastb = 0;
    bit got = 0;
    @(posedge clk); #1;
    col_max = 11'(w); row_max = 11'(h); start = 1; out_ready = 1;
    cyc = 0; nb = 0; nbz = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        nb++;
        if (!border) nbz++;
      end
      got = done;
      if (!got) begin
        @(posedge clk); #1;
        start = md == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
        if (md == 3) begin
          col_max = 11'($urandom);
          row_max = 11'($urandom);
        end
        if (nb != lastb) begin
          held = 0;
          lastb = nb;
        end
        out_ready = md == 1 ? ($urandom_range(0, 3) != 0) : md == 2 ? !((nb == 2 || nb == 7) && held < 2) : 1'b1;
        if (md == 2 && !out_ready) held++;
      end
    end
    if (!got) chk("timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 0;
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask
  initial begin
    int cyc, nb, nbz, w, h;
    repeat (2) @(posedge clk);
    #1 arm = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    idle(2);
    frame(4, 3, 0, cyc, nb, nbz);
    chk("4x3_cycles", cyc, 14);
    chk("4x3_beats", nb, 12);
    frame(4, 3, 2, cyc, nb, nbz);
    chk("4x3_stall_cycles", cyc, 18);
    chk("4x3_stall_beats", nb, 12);
    frame(0, 5, 0, cyc, nb, nbz);
    chk("zero_w_cycles", cyc, 2);
    chk("zero_w_beats", nb, 0);
    frame(5, 0, 0, cyc, nb, nbz);
    chk("zero_h_cycles", cyc, 2);
    chk("zero_h_beats", nb, 0);
    frame(1, 1, 0, cyc, nb, nbz);
    chk("1x1_cycles", cyc, 3);
    chk("1x1_beats", nb, 1);
    frame(4, 4, 0, cyc, nb, nbz);
`ifdef CFA_SCAN_BORDER_EN
    chk("4x4_interior", nbz, 4);
`else
    chk("4x4_interior", nbz, 16);
`endif
    frame(4, 3, 3, cyc, nb, nbz);
    chk("restart_ignored_cycles", cyc, 14);
    chk("restart_ignored_beats", nb, 12);
    idle(1);
    @(posedge clk); #1;
    col_max = 4; row_max = 3; start = 1; out_ready = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midreset_row", int'(row), 0);
    chk("midreset_valid", int'(out_valid), 0);
    idle(3);
    frame(3, 2, 0, cyc, nb, nbz);
    chk("after_reset_cycles", cyc, 8);
    for (int i = 0; i < 25; i++) begin
      w = $urandom_range(0, 7);
      h = $urandom_range(0, 7);
      frame(w, h, $urandom_range(0, 3) == 0 ? 3 : 1, cyc, nb, nbz);
      chk("rand_beats", nb, w * h);
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end
    frame(2047, 1, 0, cyc, nb, nbz);
    chk("wide_cycles", cyc, 2049);
    frame(2, 2047, 1, cyc, nb, nbz);
    chk("tall_beats", nb, 4094);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
